// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit sampling from a baud counter,
// one-cycle valid / framing-error strobes and a busy flag.
`timescale 1ns/1ps
module uart_rx_8n1 #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic       FPGA_CLK,
    input  logic       rst_butt,
    input  logic       UART_RXD,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned DIV  = CLK_FREQ / BAUD;
    localparam int unsigned HALF = DIV / 2;
    localparam int unsigned CW   = $clog2(DIV);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t          r_state;
    logic [1:0]      r_sync;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shreg;
    logic            w_rx_s;

    assign w_rx_s = r_sync[1];

    // Synchroniser idles high so reset never looks like a start bit.
    always_ff @(posedge FPGA_CLK or negedge rst_butt) begin
        if (!rst_butt) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], UART_RXD};
        end
    end

    always_ff @(posedge FPGA_CLK or negedge rst_butt) begin
        if (!rst_butt) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_shreg   <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!w_rx_s) begin
                        r_state <= S_START;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                    end
                end
                S_START: begin
                    if (r_cnt == CW'(HALF - 1)) begin
                        r_cnt <= '0;
                        if (!w_rx_s) begin
                            r_state   <= S_DATA;
                            r_bit_cnt <= '0;
                        end else begin
                            r_state <= S_IDLE;
                            busy    <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (r_cnt == CW'(DIV - 1)) begin
                        r_cnt   <= '0;
                        r_shreg <= {w_rx_s, r_shreg[7:1]};
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (r_cnt == CW'(DIV - 1)) begin
                        r_cnt <= '0;
                        if (w_rx_s) begin
                            rx_data  <= r_shreg;
                            rx_valid <= 1'b1;
                            busy     <= 1'b0;
                            r_state  <= S_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            r_state   <= S_WAIT_HIGH;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_WAIT_HIGH: begin
                    // A held-low break must end before a new start is accepted.
                    if (w_rx_s) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Bench for uart_rx_8n1: drives serial frames on the pin and compares captured
// strobes against expected bytes and timing derived from frame geometry.
`timescale 1ns/1ps
module tb_uart_rx_8n1;

    localparam int DIV = 434;
    localparam int LAT_MIN = 4123;
    localparam int LAT_MAX = 4128;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t_fall = 0;

    logic [7:0] exp_last = 8'h00;

    logic [7:0] cap_data[$];
    int         cap_cyc[$];
    int         cap_ferr[$];
    int         viol_width = 0;
    int         viol_overlap = 0;
    int         viol_busy = 0;
    logic       prev_v = 1'b0;
    logic       prev_f = 1'b0;

    uart_rx_8n1 #(.CLK_FREQ(50_000_000), .BAUD(115200)) dut (
        .FPGA_CLK (clk),
        .rst_butt (rst_n),
        .UART_RXD (rxd),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor: records every pulse and any pulse-shape rule violation.
    always @(posedge clk) begin
        #1;
        if (rx_valid) begin
            cap_data.push_back(rx_data);
            cap_cyc.push_back(cyc);
            if (prev_v) viol_width++;
            if (frame_err) viol_overlap++;
            if (busy) viol_busy++;
        end
        if (frame_err) begin
            cap_ferr.push_back(cyc);
            if (prev_f) viol_width++;
        end
        prev_v = rx_valid;
        prev_f = frame_err;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic v, input int period);
        rxd = v;
        repeat (period) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input int period, input logic stop);
        t_fall = cyc;
        drive_bit(1'b0, period);
        for (int i = 0; i < 8; i++) drive_bit(b[i], period);
        drive_bit(stop, period);
    endtask

    task automatic clear_caps();
        cap_data.delete();
        cap_cyc.delete();
        cap_ferr.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(5);
        checks++;
        if ({rx_data, rx_valid, frame_err, busy} !== 11'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h/%b/%b/%b exp=00/0/0/0", rx_data, rx_valid, frame_err, busy);
        end
        rst_n = 1'b1;
        idle(10);
    endtask

    task automatic test_single();
        logic [7:0] got;
        int lat;
        clear_caps();
        send_frame(8'hA5, DIV, 1'b1);
        idle(20);
        exp_last = 8'hA5;
        checks++;
        if (cap_data.size() != 1) begin
            failures++;
            $display("FAIL a5_count got=%0d exp=1", cap_data.size());
        end
        got = (cap_data.size() > 0) ? cap_data[0] : 8'hxx;
        lat = (cap_cyc.size() > 0) ? cap_cyc[0] - t_fall : -1;
        checks++;
        if (got !== 8'hA5) begin
            failures++;
            $display("FAIL a5_data got=%h exp=a5", got);
        end
        checks++;
        if (lat < LAT_MIN || lat > LAT_MAX) begin
            failures++;
            $display("FAIL a5_latency got=%0d exp=%0d..%0d", lat, LAT_MIN, LAT_MAX);
        end
        checks++;
        if (cap_ferr.size() != 0) begin
            failures++;
            $display("FAIL a5_frame_err got=%0d exp=0", cap_ferr.size());
        end
    endtask

    task automatic test_glitch();
        int t0;
        int dt;
        clear_caps();
        t0 = cyc;
        rxd = 1'b0;
        idle(100);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL glitch_busy_high got=%b exp=1", busy);
        end
        rxd = 1'b1;
        dt = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                dt = cyc - t0;
                break;
            end
        end
        checks++;
        if (dt < 216 || dt > 222) begin
            failures++;
            $display("FAIL glitch_busy_fall got=%0d exp=216..222", dt);
        end
        idle(500);
        checks++;
        if (cap_data.size() != 0 || cap_ferr.size() != 0) begin
            failures++;
            $display("FAIL glitch_no_output got=%0d/%0d exp=0/0", cap_data.size(), cap_ferr.size());
        end
    endtask

    task automatic test_framing();
        int lat;
        clear_caps();
        send_frame(8'h3C, DIV, 1'b0);
        idle(2000);
        checks++;
        if (cap_ferr.size() != 1 || cap_data.size() != 0) begin
            failures++;
            $display("FAIL ferr_counts got=%0d/%0d exp=1/0", cap_ferr.size(), cap_data.size());
        end
        lat = (cap_ferr.size() > 0) ? cap_ferr[0] - t_fall : -1;
        checks++;
        if (lat < LAT_MIN || lat > LAT_MAX) begin
            failures++;
            $display("FAIL ferr_latency got=%0d exp=%0d..%0d", lat, LAT_MIN, LAT_MAX);
        end
        checks++;
        if (rx_data !== exp_last) begin
            failures++;
            $display("FAIL ferr_data_hold got=%h exp=%h", rx_data, exp_last);
        end
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL ferr_busy_in_break got=%b exp=1", busy);
        end
        rxd = 1'b1;
        idle(10);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL ferr_release_idle got=%b exp=0", busy);
        end
    endtask

    task automatic test_back_to_back();
        int tf0;
        int tf1;
        int gap;
        clear_caps();
        send_frame(8'h00, DIV, 1'b1);
        tf0 = t_fall;
        send_frame(8'hFF, DIV, 1'b1);
        tf1 = t_fall;
        idle(20);
        exp_last = 8'hFF;
        checks++;
        if (cap_data.size() != 2) begin
            failures++;
            $display("FAIL b2b_count got=%0d exp=2", cap_data.size());
        end else begin
            checks++;
            if (cap_data[0] !== 8'h00 || cap_data[1] !== 8'hFF) begin
                failures++;
                $display("FAIL b2b_data got=%h,%h exp=00,ff", cap_data[0], cap_data[1]);
            end
            gap = cap_cyc[1] - cap_cyc[0];
            checks++;
            if (gap < (tf1 - tf0) - 1 || gap > (tf1 - tf0) + 1) begin
                failures++;
                $display("FAIL b2b_spacing got=%0d exp=%0d", gap, tf1 - tf0);
            end
        end
    endtask

    task automatic test_baud_tolerance();
        logic [7:0] got0;
        logic [7:0] got1;
        clear_caps();
        send_frame(8'h55, 442, 1'b1);
        idle(50);
        send_frame(8'hAA, 424, 1'b1);
        idle(50);
        exp_last = 8'hAA;
        got0 = (cap_data.size() > 0) ? cap_data[0] : 8'hxx;
        got1 = (cap_data.size() > 1) ? cap_data[1] : 8'hxx;
        checks++;
        if (cap_data.size() != 2 || got0 !== 8'h55 || got1 !== 8'hAA || cap_ferr.size() != 0) begin
            failures++;
            $display("FAIL baud_tol got=%0d:%h,%h ferr=%0d exp=2:55,aa ferr=0",
                     cap_data.size(), got0, got1, cap_ferr.size());
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b;
        logic [7:0] got;
        b = 8'h5A;
        clear_caps();
        drive_bit(1'b0, DIV);
        for (int i = 0; i < 4; i++) drive_bit(b[i], DIV);
        rxd = b[4];
        idle(200);
        rst_n = 1'b0;
        rxd = 1'b1;
        exp_last = 8'h00;
        idle(3);
        checks++;
        if ({rx_data, rx_valid, frame_err, busy} !== 11'd0) begin
            failures++;
            $display("FAIL midreset_outputs got=%h/%b/%b/%b exp=00/0/0/0", rx_data, rx_valid, frame_err, busy);
        end
        idle(50);
        rst_n = 1'b1;
        idle(100);
        checks++;
        if (cap_data.size() != 0 || cap_ferr.size() != 0) begin
            failures++;
            $display("FAIL midreset_aborted got=%0d/%0d exp=0/0", cap_data.size(), cap_ferr.size());
        end
        send_frame(8'h81, DIV, 1'b1);
        idle(20);
        exp_last = 8'h81;
        got = (cap_data.size() > 0) ? cap_data[0] : 8'hxx;
        checks++;
        if (cap_data.size() != 1 || got !== 8'h81 || rx_data !== 8'h81) begin
            failures++;
            $display("FAIL midreset_recover got=%0d:%h rx_data=%h exp=1:81 rx_data=81", cap_data.size(), got, rx_data);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        int period;
        clear_caps();
        for (int n = 0; n < 6; n++) begin
            b = 8'($urandom);
            period = int'($urandom_range(440, 428));
            send_frame(b, period, 1'b1);
            exp_q.push_back(b);
            idle(int'($urandom_range(40, 0)));
        end
        idle(20);
        exp_last = exp_q[exp_q.size() - 1];
        checks++;
        if (cap_data.size() != exp_q.size()) begin
            failures++;
            $display("FAIL rand_count got=%0d exp=%0d", cap_data.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (cap_data[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL rand_data[%0d] got=%h exp=%h", i, cap_data[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (rx_data !== exp_last) begin
            failures++;
            $display("FAIL rand_last_data got=%h exp=%h", rx_data, exp_last);
        end
    endtask

    task automatic test_pulse_rules();
        checks++;
        if (viol_width != 0 || viol_overlap != 0 || viol_busy != 0) begin
            failures++;
            $display("FAIL pulse_rules got=width:%0d overlap:%0d busy:%0d exp=0/0/0",
                     viol_width, viol_overlap, viol_busy);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        idle(100);
        test_glitch();
        test_framing();
        idle(100);
        test_back_to_back();
        idle(100);
        test_baud_tolerance();
        idle(100);
        test_reset_midframe();
        idle(100);
        test_random();
        test_pulse_rules();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
